// File: rtl/cluster_clock_gating_ctrl.sv
// Multi-channel clock-gating controller: per-channel idle/wake FSM, latch-based
// glitch-free clock gate and a saturating gated-cycle counter for each channel.
module cluster_clock_gating_ctrl #(
    parameter int NCH         = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int STAT_W      = 32,
    parameter bit BYPASS      = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NCH-1:0]          act_i,
    input  logic [NCH-1:0]          auto_en_i,
    input  logic                    test_en_i,
    input  logic                    stat_clr_i,
    output logic [NCH-1:0]          gate_en_o,
    output logic [NCH-1:0]          rdy_o,
    output logic [NCH-1:0]          gated_o,
    output logic [NCH*STAT_W-1:0]   stat_o,
    output logic [NCH-1:0]          clk_o
);

    localparam int IW = $clog2(IDLE_CYCLES);
    localparam int WW = $clog2(WAKE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_IDLE = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } state_e;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_e              state_q, state_d;
        logic [IW-1:0]       idle_cnt_q, idle_cnt_d;
        logic [WW-1:0]       wake_cnt_q, wake_cnt_d;
        logic [STAT_W-1:0]   stat_q, stat_d;
        logic                gate_en_q, gate_en_d;
        logic                rdy_q, rdy_d;
        logic                gated_q, gated_d;
        logic                wake_req;

        assign wake_req = act_i[c] | ~auto_en_i[c];

        always_comb begin
            state_d    = state_q;
            idle_cnt_d = idle_cnt_q;
            wake_cnt_d = wake_cnt_q;
            case (state_q)
                ST_ON: begin
                    if (!wake_req) begin
                        state_d    = ST_IDLE;
                        idle_cnt_d = IW'(1);
                    end
                end
                ST_IDLE: begin
                    if (wake_req) begin
                        state_d    = ST_ON;
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == IW'(IDLE_CYCLES - 1)) begin
                        state_d    = ST_OFF;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IW'(1);
                    end
                end
                ST_OFF: begin
                    if (wake_req) begin
                        state_d    = ST_WAKE;
                        wake_cnt_d = '0;
                    end
                end
                ST_WAKE: begin
                    // Activity is ignored here so a wake always completes its settling window
                    if (wake_cnt_q == WW'(WAKE_CYCLES - 1)) begin
                        state_d    = ST_ON;
                        wake_cnt_d = '0;
                    end else begin
                        wake_cnt_d = wake_cnt_q + WW'(1);
                    end
                end
                default: begin
                    state_d = ST_ON;
                end
            endcase
        end

        always_comb begin
            stat_d = stat_q;
            if (stat_clr_i) begin
                stat_d = '0;
            end else if (state_q == ST_OFF && stat_q != '1) begin
                stat_d = stat_q + STAT_W'(1);
            end
            gate_en_d = (state_d != ST_OFF);
            rdy_d     = (state_d == ST_ON) || (state_d == ST_IDLE);
            gated_d   = (state_d == ST_OFF);
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q    <= ST_ON;
                idle_cnt_q <= '0;
                wake_cnt_q <= '0;
                stat_q     <= '0;
                gate_en_q  <= 1'b1;
                rdy_q      <= 1'b1;
                gated_q    <= 1'b0;
            end else begin
                state_q    <= state_d;
                idle_cnt_q <= idle_cnt_d;
                wake_cnt_q <= wake_cnt_d;
                stat_q     <= stat_d;
                gate_en_q  <= gate_en_d;
                rdy_q      <= rdy_d;
                gated_q    <= gated_d;
            end
        end

        assign gate_en_o[c]                = gate_en_q;
        assign rdy_o[c]                    = rdy_q;
        assign gated_o[c]                  = gated_q;
        assign stat_o[c*STAT_W +: STAT_W]  = stat_q;

        if (BYPASS) begin : g_bypass
            assign clk_o[c] = clk_i;
        end else begin : g_gate
            logic en_latch;
            // rst_i keeps the clock running before gate_en_q has been initialised
            always_latch begin
                if (!clk_i) begin
                    en_latch = gate_en_q | test_en_i | rst_i;
                end
            end
            assign clk_o[c] = clk_i & en_latch;
        end
    end

endmodule

// File: tb/tb_cluster_clock_gating_ctrl.sv
// Self-checking bench for cluster_clock_gating_ctrl: directed phases plus random
// traffic, compared each cycle against a counting behavioural model.
module tb_cluster_clock_gating_ctrl;

    localparam int NCH       = 4;
    localparam int IDLE      = 8;
    localparam int WAKE      = 2;
    localparam int STAT_W    = 4;
    localparam int STAT_MAX  = (1 << STAT_W) - 1;

    logic                   clk_i;
    logic                   rst_i;
    logic [NCH-1:0]         act_i;
    logic [NCH-1:0]         auto_en_i;
    logic                   test_en_i;
    logic                   stat_clr_i;
    logic [NCH-1:0]         gate_en_o;
    logic [NCH-1:0]         rdy_o;
    logic [NCH-1:0]         gated_o;
    logic [NCH*STAT_W-1:0]  stat_o;
    logic [NCH-1:0]         clk_o;

    int errors = 0;
    int checks = 0;

    // Model: count of consecutive idle samples, off flag, cycles left in settling
    int m_run [NCH];
    bit m_off [NCH];
    int m_wake[NCH];
    int m_stat[NCH];
    logic [NCH-1:0] exp_clk;

    cluster_clock_gating_ctrl #(
        .NCH(NCH), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .STAT_W(STAT_W), .BYPASS(1'b0)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .act_i(act_i), .auto_en_i(auto_en_i),
        .test_en_i(test_en_i), .stat_clr_i(stat_clr_i), .gate_en_o(gate_en_o),
        .rdy_o(rdy_o), .gated_o(gated_o), .stat_o(stat_o), .clk_o(clk_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < NCH; c++) begin
            m_run[c] = 0; m_off[c] = 1'b0; m_wake[c] = 0; m_stat[c] = 0;
        end
    endtask

    task automatic modelStep();
        bit idle;
        if (rst_i) begin
            modelReset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            if (stat_clr_i) m_stat[c] = 0;
            else if (m_off[c] && m_stat[c] < STAT_MAX) m_stat[c]++;
            idle = !act_i[c] && auto_en_i[c];
            if (m_off[c]) begin
                if (!idle) begin
                    m_off[c]  = 1'b0;
                    m_wake[c] = WAKE;
                end
            end else if (m_wake[c] > 0) begin
                m_wake[c]--;
            end else if (!idle) begin
                m_run[c] = 0;
            end else begin
                m_run[c]++;
                if (m_run[c] == IDLE) begin
                    m_off[c] = 1'b1;
                    m_run[c] = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] act, input logic [NCH-1:0] auto_en,
                                 input logic test, input logic clr, input logic rst);
        act_i      = act;
        auto_en_i  = auto_en;
        test_en_i  = test;
        stat_clr_i = clr;
        rst_i      = rst;
        // The next high phase carries whatever the gate latches during this low phase
        for (int c = 0; c < NCH; c++) exp_clk[c] = !m_off[c] || test || rst;
    endtask

    task automatic checkOutput();
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("gate_en[%0d]", c), 32'(gate_en_o[c]), 32'(!m_off[c]));
            check($sformatf("rdy[%0d]", c),     32'(rdy_o[c]),     32'(!m_off[c] && m_wake[c] == 0));
            check($sformatf("gated[%0d]", c),   32'(gated_o[c]),   32'(m_off[c]));
            check($sformatf("stat[%0d]", c),    32'(stat_o[c*STAT_W +: STAT_W]), 32'(m_stat[c]));
            check($sformatf("clk_hi[%0d]", c),  32'(clk_o[c]),     32'(exp_clk[c]));
        end
    endtask

    task automatic cycle(input logic [NCH-1:0] act, input logic [NCH-1:0] auto_en,
                         input logic test, input logic clr, input logic rst);
        applyStimulus(act, auto_en, test, clr, rst);
        @(posedge clk_i);
        modelStep();
        #1;
        checkOutput();
        @(negedge clk_i);
        #1;
        check("clk_lo", 32'(clk_o), 32'(0));
    endtask

    initial begin
        logic [NCH-1:0] ra, re;
        modelReset();
        applyStimulus('0, '1, 1'b0, 1'b0, 1'b1);

        $display("[TB] reset and idle gating");
        repeat (2) cycle('0, '1, 1'b0, 1'b0, 1'b1);
        repeat (14) cycle('0, '1, 1'b0, 1'b0, 1'b0);

        $display("[TB] wake with activity toggling inside the window");
        cycle(4'b0001, '1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(NCH'(i % 2), '1, 1'b0, 1'b0, 1'b0);

        $display("[TB] near miss then gating");
        cycle('0, '1, 1'b0, 1'b0, 1'b1);
        repeat (7) cycle('0, '1, 1'b0, 1'b0, 1'b0);
        cycle('1, '1, 1'b0, 1'b0, 1'b0);
        repeat (10) cycle('0, '1, 1'b0, 1'b0, 1'b0);

        $display("[TB] independent channels");
        cycle('0, '1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++)
            cycle({1'((i / 3) % 2), 1'b0, 1'b1, 1'b0}, 4'b1011, 1'b0, 1'b0, 1'b0);

        $display("[TB] test override, saturation and clear");
        repeat (4) cycle(4'b0010, 4'b1011, 1'b1, 1'b0, 1'b0);
        repeat (16) cycle(4'b0010, 4'b1011, 1'b0, 1'b0, 1'b0);
        cycle(4'b0010, 4'b1011, 1'b0, 1'b1, 1'b0);
        repeat (2) cycle(4'b0010, 4'b1011, 1'b0, 1'b0, 1'b0);

        $display("[TB] auto enable dropped while gated");
        repeat (2) cycle('0, 4'b1110, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle('0, '1, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset during wake and off");
        repeat (10) cycle('0, '1, 1'b0, 1'b0, 1'b0);
        cycle(4'b0001, '1, 1'b0, 1'b0, 1'b0);
        cycle('0, '1, 1'b0, 1'b0, 1'b1);
        repeat (2) cycle('0, '1, 1'b0, 1'b0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NCH; c++) begin
                ra[c] = ($urandom_range(0, 7) == 0);
                re[c] = ($urandom_range(0, 15) != 0);
            end
            cycle(ra, re, $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 63) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cluster_clock_gating_ctrl.md
# cluster_clock_gating_ctrl

Parametrised, multi-channel clock-gating controller with an integrated glitch-free gate per channel. Each channel watches an activity input, gates its clock after a programmable idle run, and on renewed activity restarts the clock and holds a ready flag low for a settling window. The block sits between the core/cluster activity sources and the gated clock trees (register-file banks, peripheral clusters). It also exports per-channel gated-cycle statistics.

## Interface
Parameters:
- NCH, 4, number of gated channels (≥1)
- IDLE_CYCLES, 8, consecutive idle samples before gating (≥2)
- WAKE_CYCLES, 2, cycles with clock running before ready reasserts (≥1)
- STAT_W, 32, width of each gated-cycle counter
- BYPASS, 0, 1 = clk_o[c] wired straight to clk_i (FPGA/simulation); FSM, statistics and rdy_o still operate

Ports:
- clk_i  in  1  free-running source clock
- rst_i  in  1  reset; synchronous, active-high
- act_i  in  NCH  per-channel activity; 1 = channel needs its clock
- auto_en_i  in  NCH  per-channel auto-gating enable; 0 = never gate
- test_en_i  in  1  scan/test override; forces every clk_o running, FSM unaffected
- stat_clr_i  in  1  synchronous clear of all statistics counters
- gate_en_o  out  NCH  registered gate enable (pre-latch)
- rdy_o  out  NCH  1 = channel clock running and settled
- gated_o  out  NCH  1 = channel in OFF
- stat_o  out  NCH*STAT_W  per-channel gated-cycle count, channel c at [c*STAT_W +: STAT_W]
- clk_o  out  NCH  gated clocks

## Operation
- Per-channel FSM, states ON, IDLE, OFF, WAKE; idle counter (clog2(IDLE_CYCLES) bits); wake counter (clog2(WAKE_CYCLES+1) bits).
- ON: act=0 and auto_en=1 → IDLE, idle_cnt←1; else stay.
- IDLE: act=1 or auto_en=0 → ON. Otherwise, if idle_cnt==IDLE_CYCLES-1 → OFF; else idle_cnt++.
- Net effect: OFF is entered after act=0 is sampled on exactly IDLE_CYCLES consecutive edges. Any act=1 restarts the count.
- OFF: act=1 or auto_en=0 → WAKE, wake_cnt←0.
- WAKE: wake_cnt++. When wake_cnt==WAKE_CYCLES-1 → ON. act and auto_en are ignored in WAKE, so there is no direct WAKE→OFF path.
- gate_en_o[c] = register of (next state ≠ OFF).
- rdy_o[c] = registered, 1 in ON and IDLE.
- gated_o[c] = registered, 1 in OFF.
- Gate cell, BYPASS=0:
  - latch transparent while clk_i low, D = gate_en_o[c] | test_en_i
  - clk_o[c] = clk_i & latch_q
  - no glitches or truncated high phases
- Statistics: stat counter increments on every cycle the channel is in OFF. It saturates at all-ones (no wrap). stat_clr_i has priority over increment.
- Channels are fully independent; simultaneous events on different channels do not interact.

## Timing
- Reset (rst_i high at an edge), all channels:
  - state ON, counters 0
  - gate_en_o=all 1, rdy_o=all 1, gated_o=0, stat_o=0
  - clocks run during and after reset
- Reset mid-operation, any state (including OFF and WAKE): next edge returns to ON with gate_en_o=1. The clock restarts without a wake window; rdy_o=1 immediately.
- Gating latency: act low from edge k (sampled at k..k+IDLE_CYCLES-1). gate_en_o falls after edge k+IDLE_CYCLES-1, gated_o rises the same edge, and the clk_o high phase at edge k+IDLE_CYCLES is the first suppressed.
- Wake latency: act sampled 1 at edge m while in OFF. gate_en_o rises after edge m, and the first clk_o pulse is at edge m+1. rdy_o rises after edge m+WAKE_CYCLES.
- act=1 on the same edge IDLE would gate (idle_cnt==IDLE_CYCLES-1) → ON; no gating.
- auto_en falling in OFF behaves as a wake. auto_en=0 in ON keeps the channel in ON.
- test_en_i takes effect on clk_o from the next clk_i low phase. gate_en_o, rdy_o and gated_o are unchanged by it.

## Test plan
- Reset then idle, NCH=4, IDLE_CYCLES=8: after reset, outputs are 1/1/0/0. Hold act=0, auto_en=F: gate_en_o falls after the 8th sampled edge, clk_o silent from the next edge, and stat_o increments by 1 per OFF cycle.
- Near-miss: act=0 for 7 edges, then act=1 → no gating, gated_o stays 0. Follow with act=0 for 8 edges → gates.
- Wake, WAKE_CYCLES=2: assert act in OFF → gate_en_o=1 next cycle, first clk_o pulse 1 cycle later, rdy_o=1 two edges after the act sample. Toggling act in WAKE does not alter timing.
- Independence: ch0 gated, ch1 active, ch2 auto_en=0, ch3 toggling every 3 cycles → only ch0 gated; ch3 never gates.
- Overrides: test_en_i=1 while ch0 is OFF → clk_o[0] runs glitch-free and gated_o[0] stays 1. Set STAT_W=4 to reach saturation: stat holds 15; stat_clr_i → 0.
- Reset while ch0 is in WAKE and ch1 is in OFF → both channels in ON with rdy_o=1 after one edge, and stat_o=0.
